// File: rtl/mdr_mem_reader_pkg.sv
// Shared definitions for the MDR read path: FSM state encodings and default widths.
package mdr_mem_reader_pkg;

  localparam int unsigned RD_DATA_W = 32;
  localparam int unsigned RD_ADDR_W = 9;

  // Encoding 2'd3 is unused and is steered back to RD_IDLE by the FSM.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/mdr_mem_reader_timeout_ctr.sv
// 8-bit saturating wait-cycle counter; flags expiry when the count reaches TIMEOUT-1.
module rd_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic sclr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (sclr) begin
      count <= '0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_mem_reader.sv
// Memory read sequencer: latches MAR, runs a req/ack read with timeout and captures
// the returned word into the MDR; the MDR can also be loaded directly from the bus.
module mdr_mem_reader
  import mdr_mem_reader_pkg::*;
#(
  parameter int unsigned DATA_W  = RD_DATA_W,
  parameter int unsigned ADDR_W  = RD_ADDR_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  rd_state_e state_q, state_d;
  logic      req_d, busy_d, done_d;
  logic      start_ok, in_req, expired;

  assign start_ok = (state_q == RD_IDLE) && start;
  assign in_req   = (state_q == RD_REQ);

  rd_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .clr     (clr),
    .sclr    (start_ok),
    .en      (in_req && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RD_IDLE;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_req <= req_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (start) state_d = RD_REQ;
      RD_REQ: begin
        if (mem_ack)      state_d = RD_DONE;
        else if (expired) state_d = RD_IDLE;
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered with it.
  always_comb begin
    req_d  = (state_d == RD_REQ);
    busy_d = (state_d != RD_IDLE);
    done_d = (state_d == RD_DONE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mdr_q    <= '0;
      mem_addr <= '0;
      err      <= 1'b0;
    end else begin
      if (start_ok) begin
        mem_addr <= addr;
        err      <= 1'b0;
      end else if ((state_q == RD_IDLE) && mdr_in) begin
        mdr_q <= bus_in;
      end
      if (in_req && mem_ack) begin
        mdr_q <= mem_data;
      end else if (in_req && expired) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdr_mem_reader.sv
// Bench for mdr_mem_reader: directed vector table, hand-written reset/load sequences
// and randomized reads checked against a transaction-level model.
module tb_mdr_mem_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int TOUT = 15;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] bus_in = '0;
  logic          mdr_in = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] mdr_q;
  logic          busy, done, err;

  mdr_mem_reader #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TOUT)) dut (
    .clk(clk), .clr(clr), .start(start), .addr(addr), .bus_in(bus_in),
    .mdr_in(mdr_in), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .mdr_q(mdr_q), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] ram [512];
  logic [DW-1:0] model_mdr = '0;

  typedef struct {
    logic [AW-1:0] a;
    int            ack_at;   // REQ cycle index (0-based) that sees ack; -1 = never
    logic          with_load;
    int            req_e;
    int            idle_e;
    int            done_e;
    logic          err_e;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one read and acts as the RAM; returns observed cycle counts.
  task automatic run_read(input logic [AW-1:0] a, input int ack_at, input logic with_load,
                          output int req_cyc, output int done_cyc, output int idle_cyc,
                          output logic addr_ok);
    start = 1'b1; addr = a; mdr_in = with_load; bus_in = 32'h1234;
    req_cyc = 0; done_cyc = 0; idle_cyc = -1; addr_ok = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      start = 1'b0; mdr_in = 1'b0; mem_ack = 1'b0; mem_data = $urandom;
      if (mem_req) begin
        if (mem_addr !== a) addr_ok = 1'b0;
        if (req_cyc == ack_at) begin mem_ack = 1'b1; mem_data = ram[a]; end
        req_cyc++;
      end
      if (done) done_cyc++;
      if (!busy) begin idle_cyc = c; break; end
      // Traffic while busy must be ignored.
      start  = 1'($urandom_range(0, 1));
      mdr_in = 1'($urandom_range(0, 1));
      addr   = AW'($urandom);
      bus_in = $urandom;
    end
    start = 1'b0; mdr_in = 1'b0; mem_ack = 1'b0;
  endtask

  // Transaction-level expectation: a read succeeds iff ack arrives within TOUT REQ cycles.
  task automatic read_and_check(input string tag, input logic [AW-1:0] a, input int ack_at,
                                input logic with_load);
    int   rq, dn, idl;
    logic aok;
    logic ok;
    ok = (ack_at >= 0) && (ack_at < TOUT);
    run_read(a, ack_at, with_load, rq, dn, idl, aok);
    if (ok) model_mdr = ram[a];
    check({tag, ".req_cycles"}, rq, ok ? ack_at + 1 : TOUT);
    check({tag, ".idle_edge"}, idl, ok ? ack_at + 3 : TOUT + 1);
    check({tag, ".done_pulses"}, dn, ok ? 1 : 0);
    check({tag, ".err"}, {31'b0, err}, {31'b0, !ok});
    check({tag, ".mdr_q"}, mdr_q, model_mdr);
    check({tag, ".addr_stable"}, {31'b0, aok}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = $urandom;
    ram[9'h012] = 32'hDEADBEEF;
    ram[9'h000] = 32'hA5A5_0001;

    vecs[0] = '{9'h012,  0, 1'b0,  1,  3, 1, 1'b0};
    vecs[1] = '{9'h0A5,  3, 1'b0,  4,  6, 1, 1'b0};
    vecs[2] = '{9'h1FF, -1, 1'b0, 15, 16, 0, 1'b1};
    vecs[3] = '{9'h000,  0, 1'b1,  1,  3, 1, 1'b0};
    vecs[4] = '{9'h033, 14, 1'b0, 15, 17, 1, 1'b0};
    vecs[5] = '{9'h100, 15, 1'b0, 15, 16, 0, 1'b1};

    #2;
    check("reset.mem_req", {31'b0, mem_req}, 32'd0);
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.done", {31'b0, done}, 32'd0);
    check("reset.err", {31'b0, err}, 32'd0);
    check("reset.mdr_q", mdr_q, 32'd0);
    check("reset.mem_addr", {23'b0, mem_addr}, 32'd0);
    #20 clr = 1'b1;
    @(posedge clk); #1;

    // Direct bus load in IDLE.
    mdr_in = 1'b1; bus_in = 32'h1234;
    @(posedge clk); #1;
    mdr_in = 1'b0;
    model_mdr = 32'h1234;
    check("mdr_in.load", mdr_q, 32'h1234);

    for (int i = 0; i < 6; i++) begin
      int   rq, dn, idl;
      logic aok;
      logic [DW-1:0] mdr_exp;
      mdr_exp = (vecs[i].err_e) ? model_mdr : ram[vecs[i].a];
      run_read(vecs[i].a, vecs[i].ack_at, vecs[i].with_load, rq, dn, idl, aok);
      model_mdr = mdr_exp;
      check($sformatf("vec%0d.req_cycles", i), rq, vecs[i].req_e);
      check($sformatf("vec%0d.idle_edge", i), idl, vecs[i].idle_e);
      check($sformatf("vec%0d.done_pulses", i), dn, vecs[i].done_e);
      check($sformatf("vec%0d.err", i), {31'b0, err}, {31'b0, vecs[i].err_e});
      check($sformatf("vec%0d.mdr_q", i), mdr_q, mdr_exp);
      check($sformatf("vec%0d.addr_stable", i), {31'b0, aok}, 32'd1);
    end

    // Reset in the middle of a read, then a stray ack.
    start = 1'b1; addr = 9'h055;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midreset.pre_req", {31'b0, mem_req}, 32'd1);
    #2 clr = 1'b0;
    #1;
    check("midreset.mem_req", {31'b0, mem_req}, 32'd0);
    check("midreset.busy", {31'b0, busy}, 32'd0);
    check("midreset.done", {31'b0, done}, 32'd0);
    check("midreset.err", {31'b0, err}, 32'd0);
    check("midreset.mdr_q", mdr_q, 32'd0);
    #2 clr = 1'b1;
    mem_ack = 1'b1; mem_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    model_mdr = '0;
    check("midreset.late_ack_mdr", mdr_q, 32'd0);
    check("midreset.late_ack_busy", {31'b0, busy}, 32'd0);
    check("midreset.late_ack_done", {31'b0, done}, 32'd0);

    // Randomized reads interleaved with bus loads.
    for (int t = 0; t < 150; t++) begin
      int ack_at;
      if ($urandom_range(0, 3) == 0) begin
        mdr_in = 1'b1; bus_in = $urandom;
        model_mdr = bus_in;
        @(posedge clk); #1;
        mdr_in = 1'b0;
        check("rand.bus_load", mdr_q, model_mdr);
      end
      ack_at = int'($urandom_range(0, 21)) - 1;
      read_and_check("rand", AW'($urandom), ack_at, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
